// File: rtl/messbauer_velocity_profile_generator.sv
// messbauer_velocity_profile_generator: sawtooth/triangle velocity reference with sync pulse and period counter
module messbauer_velocity_profile_generator #(
  parameter int DATA_WIDTH  = 12,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   areset_n_i,
  input  logic                   enable_i,
  input  logic                   cfg_mode_i,
  input  logic [DATA_WIDTH-1:0]  cfg_peak_i,
  input  logic [DATA_WIDTH-1:0]  cfg_up_step_i,
  input  logic [DATA_WIDTH-1:0]  cfg_down_step_i,
  output logic [DATA_WIDTH-1:0]  out_value_o,
  output logic                   dir_o,
  output logic                   period_start_o,
  output logic [COUNT_WIDTH-1:0] period_count_o,
  output logic                   busy_o,
  output logic                   cfg_error_o
);
  typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q, out_d, peak_q, peak_d, up_q, up_d, dn_q, dn_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d, ps_q, ps_d, err_q, err_d, seen_q, seen_d;
  logic valid, restart;
  logic [DATA_WIDTH:0] sum;
  assign valid = (|cfg_peak_i) && (|cfg_up_step_i) && (cfg_mode_i || (|cfg_down_step_i));
  assign sum = {1'b0, out_q} + {1'b0, up_q};
  // seen_q suppresses repeated error pulses while the same bad request is held
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    peak_d  = peak_q;
    up_d    = up_q;
    dn_d    = dn_q;
    ps_d    = 1'b0;
    err_d   = 1'b0;
    restart = 1'b0;
    case (state_q)
      RISE: begin
        if (sum >= {1'b0, peak_q}) begin
          out_d   = peak_q;
          dir_d   = 1'b1;
          state_d = FALL;
        end else out_d = sum[DATA_WIDTH-1:0];
      end
      FALL: begin
        if (out_q > dn_q) out_d = out_q - dn_q;
        else begin
          out_d   = '0;
          dir_d   = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
          restart = enable_i;
        end
      end
      default: restart = enable_i;
    endcase
    if (restart && valid) begin
      state_d = RISE;
      ps_d    = 1'b1;
      peak_d  = cfg_peak_i;
      up_d    = cfg_up_step_i;
      dn_d    = cfg_mode_i ? cfg_up_step_i : cfg_down_step_i;
    end else err_d = restart && !seen_q;
    seen_d = restart && !valid;
  end
  always_ff @(negedge clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state_q <= IDLE;
      out_q   <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      peak_q  <= '0;
      up_q    <= '0;
      dn_q    <= '0;
      ps_q    <= 1'b0;
      err_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      peak_q  <= peak_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      ps_q    <= ps_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
    end
  end
  assign out_value_o    = out_q;
  assign dir_o          = dir_q;
  assign period_start_o = ps_q;
  assign period_count_o = cnt_q;
  assign busy_o         = state_q != IDLE;
  assign cfg_error_o    = err_q;
endmodule

// File: tb/tb_messbauer_velocity_profile_generator.sv
// tb_messbauer_velocity_profile_generator: directed checks of profile shapes, config latching, stop, errors, reset, count wrap
module tb_messbauer_velocity_profile_generator;
  logic clk = 1'b0, areset_n = 1'b0, en = 1'b0, mode = 1'b0, en2 = 1'b0;
  logic [11:0] peak = '0, up = '0, dn = '0, out, out2;
  logic dir, ps, busy, err, dir2, ps2, busy2, err2;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int n_chk = 0, n_pass = 0;
  int tri_v[6] = '{0, 3, 6, 8, 5, 2};
  always #5 clk = ~clk;
  messbauer_velocity_profile_generator dut (
    .clk_i(clk), .areset_n_i(areset_n), .enable_i(en), .cfg_mode_i(mode),
    .cfg_peak_i(peak), .cfg_up_step_i(up), .cfg_down_step_i(dn),
    .out_value_o(out), .dir_o(dir), .period_start_o(ps), .period_count_o(cnt),
    .busy_o(busy), .cfg_error_o(err)
  );
  messbauer_velocity_profile_generator #(.DATA_WIDTH(12), .COUNT_WIDTH(2)) dut2 (
    .clk_i(clk), .areset_n_i(areset_n), .enable_i(en2), .cfg_mode_i(1'b1),
    .cfg_peak_i(12'd2), .cfg_up_step_i(12'd1), .cfg_down_step_i(12'd0),
    .out_value_o(out2), .dir_o(dir2), .period_start_o(ps2), .period_count_o(cnt2),
    .busy_o(busy2), .cfg_error_o(err2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
  endtask
  initial begin
    repeat (2) tick;
    chk("rst_out", out, 0); chk("rst_busy", busy, 0); chk("rst_ps", ps, 0);
    chk("rst_cnt", cnt, 0); chk("rst_dir", dir, 0); chk("rst_err", err, 0);
    areset_n = 1'b1; mode = 1'b0; peak = 12'd100; up = 12'd1; dn = 12'd10; en = 1'b1;
    // sawtooth P=100 U=1 D=10
    tick; chk("saw_start_out", out, 0); chk("saw_start_ps", ps, 1); chk("saw_start_busy", busy, 1);
    for (int i = 1; i <= 100; i++) begin
      tick; chk("saw_rise", out, i); chk("saw_rise_dir", dir, (i == 100)); chk("saw_rise_ps", ps, 0);
    end
    for (int v = 90; v >= 10; v -= 10) begin
      tick; chk("saw_fall", out, v); chk("saw_fall_dir", dir, 1);
    end
    tick; chk("saw_end_out", out, 0); chk("saw_end_ps", ps, 1); chk("saw_end_cnt", cnt, 1); chk("saw_end_dir", dir, 0);
    // peak change mid-rise is deferred to next period
    for (int i = 1; i <= 10; i++) begin tick; chk("chg_rise", out, i); end
    peak = 12'd50;
    for (int i = 11; i <= 100; i++) begin tick; chk("chg_rise_old_peak", out, i); end
    for (int v = 90; v >= 10; v -= 10) begin tick; chk("chg_fall", out, v); end
    tick; chk("chg_end_ps", ps, 1); chk("chg_end_cnt", cnt, 2);
    // graceful stop requested at out=40 while rising
    for (int i = 1; i <= 40; i++) begin tick; chk("new_peak_rise", out, i); end
    en = 1'b0;
    for (int i = 41; i <= 50; i++) begin tick; chk("stop_rise", out, i); end
    chk("stop_peak_dir", dir, 1);
    for (int v = 40; v >= 10; v -= 10) begin tick; chk("stop_fall", out, v); chk("stop_fall_busy", busy, 1); end
    tick; chk("stop_out", out, 0); chk("stop_busy", busy, 0); chk("stop_ps", ps, 0); chk("stop_cnt", cnt, 3);
    repeat (3) begin tick; chk("idle_out", out, 0); chk("idle_ps", ps, 0); chk("idle_busy", busy, 0); end
    // triangle P=8 U=3
    mode = 1'b1; peak = 12'd8; up = 12'd3; dn = 12'd0; en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 6; k++) begin
        tick; chk("tri_out", out, tri_v[k]); chk("tri_dir", dir, (k >= 3)); chk("tri_ps", ps, (k == 0));
        if (k == 0) chk("tri_cnt", cnt, 3 + p);
      end
    end
    // invalid config at period boundary, then from IDLE
    up = 12'd0;
    tick; chk("bad_fall_out", out, 0); chk("bad_fall_err", err, 1); chk("bad_fall_ps", ps, 0);
    chk("bad_fall_busy", busy, 0); chk("bad_fall_cnt", cnt, 5);
    repeat (3) begin tick; chk("bad_hold_err", err, 0); chk("bad_hold_busy", busy, 0); end
    en = 1'b0;
    tick; chk("bad_off_err", err, 0);
    en = 1'b1;
    tick; chk("bad_idle_err", err, 1); chk("bad_idle_busy", busy, 0);
    repeat (2) begin tick; chk("bad_idle_hold", err, 0); end
    // asynchronous reset mid-fall
    up = 12'd3;
    tick; chk("re_ps", ps, 1); chk("re_err", err, 0);
    repeat (3) tick;
    tick; chk("pre_rst_out", out, 5); chk("pre_rst_dir", dir, 1);
    #2 areset_n = 1'b0;
    #1 chk("arst_out", out, 0); chk("arst_dir", dir, 0); chk("arst_busy", busy, 0);
    chk("arst_cnt", cnt, 0); chk("arst_ps", ps, 0); chk("arst_err", err, 0);
    tick; areset_n = 1'b1; en2 = 1'b1;
    // two-bit period counter wrap, triangle P=2 U=1
    tick; chk("w_out", out2, 0); chk("w_ps", ps2, 1); chk("w_cnt", cnt2, 0);
    for (int p = 1; p <= 4; p++) begin
      tick; chk("w_up1", out2, 1);
      tick; chk("w_peak", out2, 2); chk("w_dir", dir2, 1);
      tick; chk("w_dn1", out2, 1);
      tick; chk("w_start", ps2, 1); chk("w_zero", out2, 0); chk("w_cnt", cnt2, p & 3);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
